// File: rtl/queue_occupancy_tracker_pkg.sv
// Shared error codes and error-FSM state encoding for the occupancy tracker.
package queue_pkg;
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;

    typedef enum logic {
        ST_OK  = 1'b0,
        ST_ERR = 1'b1
    } err_st_e;
endpackage

// File: rtl/queue_occupancy_tracker_if.sv
// Gate-sensor and status bundle between the tracker (slave) and its user (master).
interface queue_occupancy_tracker_if #(
    parameter int CNT_W  = 3,
    parameter int WAIT_W = 16
);
    logic              enter_i;
    logic              leave_i;
    logic              err_clr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              error;
    logic [1:0]        err_code;
    logic [WAIT_W-1:0] wait_est;

    modport master (
        output enter_i, leave_i, err_clr,
        input  count, full, empty, almost_full, error, err_code, wait_est
    );

    modport slave (
        input  enter_i, leave_i, err_clr,
        output count, full, empty, almost_full, error, err_code, wait_est
    );
endinterface

// File: rtl/queue_occupancy_tracker_gate_edge_detect.sv
// Single-bit rising-edge detector; history resets to 1 so a level held
// high through reset does not produce an event.
module gate_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_lvl,
    output logic o_rise
);
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= 1'b1;
        else     r_q <= i_lvl;
    end

    assign o_rise = i_lvl & ~r_q;
endmodule

// File: rtl/queue_occupancy_tracker.sv
// Waiting-room occupancy counter with flags and sticky error FSM.
// Optional registered wait-time estimate under macro WAIT_ESTIMATE_EN.
module queue_occupancy_tracker
    import queue_pkg::*;
#(
    parameter int CNT_W       = 3,
    parameter int AFULL_TH    = 6,
    parameter int SERVICE_CYC = 16,
    parameter int WAIT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    queue_occupancy_tracker_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = '1;
    localparam logic [CNT_W-1:0] AF_TH   = CNT_W'(AFULL_TH);

    if (AFULL_TH < 1 || AFULL_TH > 2**CNT_W - 1 || SERVICE_CYC < 1) begin : g_param_chk
        $error("queue_occupancy_tracker: illegal AFULL_TH or SERVICE_CYC");
    end

    logic [1:0]       w_lvl;
    logic [1:0]       w_rise;
    logic             w_ent;
    logic             w_lv;
    logic             w_full;
    logic             w_empty;
    logic             w_over;
    logic             w_under;
    logic             w_err_ev;
    logic [1:0]       w_ev_code;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_count;
    err_st_e          r_state;
    logic             r_error;
    logic [1:0]       r_code;

    assign w_lvl = {bus.leave_i, bus.enter_i};

    for (genvar g = 0; g < 2; g++) begin : g_gate
        gate_edge_detect u_edge (
            .clk    (clk),
            .rst    (rst),
            .i_lvl  (w_lvl[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_ent     = w_rise[0];
    assign w_lv      = w_rise[1];
    assign w_full    = (r_count == MAX_CNT);
    assign w_empty   = (r_count == '0);
    // Simultaneous enter+leave is a pass-through and never an error.
    assign w_over    = w_ent & ~w_lv & w_full;
    assign w_under   = w_lv & ~w_ent & w_empty;
    assign w_err_ev  = w_over | w_under;
    assign w_ev_code = w_over ? ERR_OVER : ERR_UNDER;

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_ent && !w_lv && !w_full)       w_cnt_nxt = r_count + 1'b1;
        else if (w_lv && !w_ent && !w_empty) w_cnt_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_count <= '0;
        else     r_count <= w_cnt_nxt;
    end

    // A clear that coincides with a new error keeps ERR and takes the new code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_OK;
            r_error <= 1'b0;
            r_code  <= ERR_NONE;
        end else begin
            case (r_state)
                ST_OK: begin
                    if (w_err_ev) begin
                        r_state <= ST_ERR;
                        r_error <= 1'b1;
                        r_code  <= w_ev_code;
                    end
                end
                ST_ERR: begin
                    if (bus.err_clr) begin
                        if (w_err_ev) begin
                            r_code <= w_ev_code;
                        end else begin
                            r_state <= ST_OK;
                            r_error <= 1'b0;
                            r_code  <= ERR_NONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_OK;
                    r_error <= 1'b0;
                    r_code  <= ERR_NONE;
                end
            endcase
        end
    end

    assign bus.count       = r_count;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almost_full = (r_count >= AF_TH);
    assign bus.error       = r_error;
    assign bus.err_code    = r_code;

`ifdef WAIT_ESTIMATE_EN
    localparam int PW = CNT_W + 32;
    logic [PW-1:0]     w_prod;
    logic              w_sat;
    logic [WAIT_W-1:0] r_wait;

    // Built from the next count so the estimate tracks count with no lag.
    assign w_prod = PW'(w_cnt_nxt) * PW'(SERVICE_CYC);
    assign w_sat  = |(w_prod >> WAIT_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wait <= '0;
        else     r_wait <= w_sat ? '1 : WAIT_W'(w_prod);
    end

    assign bus.wait_est = r_wait;
`else
    assign bus.wait_est = '0;
`endif
endmodule

// File: tb/tb_queue_occupancy_tracker.sv
// Directed self-checking bench for queue_occupancy_tracker (CNT_W=3, AFULL_TH=6).
module tb_queue_occupancy_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    queue_occupancy_tracker_if #(.CNT_W(3), .WAIT_W(16)) bus ();

    queue_occupancy_tracker #(
        .CNT_W(3), .AFULL_TH(6), .SERVICE_CYC(16), .WAIT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic int exp_wait(input int n);
`ifdef WAIT_ESTIMATE_EN
        return n * 16;
`else
        return 0;
`endif
    endfunction

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.enter_i = 1'b0;
        bus.leave_i = 1'b0;
        bus.err_clr = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_enter();
        bus.enter_i = 1'b1; tick();
        bus.enter_i = 1'b0; tick();
    endtask

    task automatic pulse_leave();
        bus.leave_i = 1'b1; tick();
        bus.leave_i = 1'b0; tick();
    endtask

    task automatic test_reset();
        bus.enter_i = 1'b1; bus.leave_i = 1'b0; bus.err_clr = 1'b0;
        rst = 1'b1;
        tick(); tick();
        n_chk++; if (bus.count !== 3'd0) $display("FAIL rst_count: got %0d exp 0", bus.count); else n_pass++;
        n_chk++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.almost_full !== 1'b0)
            $display("FAIL rst_flags: got e%b f%b af%b exp e1 f0 af0", bus.empty, bus.full, bus.almost_full); else n_pass++;
        n_chk++; if (bus.error !== 1'b0 || bus.err_code !== 2'b00)
            $display("FAIL rst_err: got %b/%b exp 0/00", bus.error, bus.err_code); else n_pass++;
        n_chk++; if (bus.wait_est !== 16'd0) $display("FAIL rst_wait: got %0d exp 0", bus.wait_est); else n_pass++;
        rst = 1'b0;
        tick(); tick();
        n_chk++; if (bus.count !== 3'd0 || bus.empty !== 1'b1)
            $display("FAIL held_high: got cnt %0d empty %b exp 0/1", bus.count, bus.empty); else n_pass++;
        bus.enter_i = 1'b0; tick();
        bus.enter_i = 1'b1; tick();
        n_chk++; if (bus.count !== 3'd1 || bus.empty !== 1'b0)
            $display("FAIL first_edge: got cnt %0d empty %b exp 1/0", bus.count, bus.empty); else n_pass++;
        bus.enter_i = 1'b0; tick();
    endtask

    task automatic test_fill_overflow();
        apply_reset();
        for (int i = 1; i <= 7; i++) begin
            pulse_enter();
            n_chk++; if (bus.count !== 3'(i)) $display("FAIL fill_cnt%0d: got %0d exp %0d", i, bus.count, i); else n_pass++;
            n_chk++; if (bus.almost_full !== (i >= 6)) $display("FAIL fill_af%0d: got %b exp %b", i, bus.almost_full, (i >= 6)); else n_pass++;
            n_chk++; if (bus.full !== (i == 7)) $display("FAIL fill_full%0d: got %b exp %b", i, bus.full, (i == 7)); else n_pass++;
            n_chk++; if (bus.wait_est !== 16'(exp_wait(i))) $display("FAIL fill_wait%0d: got %0d exp %0d", i, bus.wait_est, exp_wait(i)); else n_pass++;
        end
        pulse_enter();
        n_chk++; if (bus.count !== 3'd7) $display("FAIL ovf_cnt: got %0d exp 7", bus.count); else n_pass++;
        n_chk++; if (bus.error !== 1'b1 || bus.err_code !== 2'b10)
            $display("FAIL ovf_err: got %b/%b exp 1/10", bus.error, bus.err_code); else n_pass++;
    endtask

    task automatic test_underflow_clear();
        apply_reset();
        pulse_leave();
        n_chk++; if (bus.count !== 3'd0) $display("FAIL unf_cnt: got %0d exp 0", bus.count); else n_pass++;
        n_chk++; if (bus.error !== 1'b1 || bus.err_code !== 2'b01)
            $display("FAIL unf_err: got %b/%b exp 1/01", bus.error, bus.err_code); else n_pass++;
        pulse_enter();
        n_chk++; if (bus.count !== 3'd1 || bus.err_code !== 2'b01)
            $display("FAIL err_count_on: got cnt %0d code %b exp 1/01", bus.count, bus.err_code); else n_pass++;
        bus.err_clr = 1'b1; tick();
        bus.err_clr = 1'b0;
        n_chk++; if (bus.error !== 1'b0 || bus.err_code !== 2'b00)
            $display("FAIL clr: got %b/%b exp 0/00", bus.error, bus.err_code); else n_pass++;
        bus.err_clr = 1'b1; tick();
        bus.err_clr = 1'b0;
        n_chk++; if (bus.error !== 1'b0 || bus.count !== 3'd1)
            $display("FAIL clr_in_ok: got err %b cnt %0d exp 0/1", bus.error, bus.count); else n_pass++;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        for (int i = 0; i < 7; i++) pulse_enter();
        bus.enter_i = 1'b1; bus.leave_i = 1'b1; tick();
        n_chk++; if (bus.count !== 3'd7 || bus.error !== 1'b0)
            $display("FAIL sim_full: got cnt %0d err %b exp 7/0", bus.count, bus.error); else n_pass++;
        bus.enter_i = 1'b0; bus.leave_i = 1'b0; tick();
        apply_reset();
        bus.enter_i = 1'b1; bus.leave_i = 1'b1; tick();
        n_chk++; if (bus.count !== 3'd0 || bus.error !== 1'b0)
            $display("FAIL sim_empty: got cnt %0d err %b exp 0/0", bus.count, bus.error); else n_pass++;
        bus.enter_i = 1'b0; bus.leave_i = 1'b0; tick();
    endtask

    task automatic test_clr_with_new_error();
        apply_reset();
        pulse_leave();
        for (int i = 0; i < 7; i++) pulse_enter();
        n_chk++; if (bus.count !== 3'd7 || bus.err_code !== 2'b01)
            $display("FAIL err_hold_fill: got cnt %0d code %b exp 7/01", bus.count, bus.err_code); else n_pass++;
        pulse_enter();
        n_chk++; if (bus.err_code !== 2'b01) $display("FAIL first_err_kept: got %b exp 01", bus.err_code); else n_pass++;
        bus.enter_i = 1'b1; bus.err_clr = 1'b1; tick();
        bus.err_clr = 1'b0;
        n_chk++; if (bus.error !== 1'b1 || bus.err_code !== 2'b10 || bus.count !== 3'd7)
            $display("FAIL clr_vs_ovf: got %b/%b cnt %0d exp 1/10 cnt 7", bus.error, bus.err_code, bus.count); else n_pass++;
        bus.enter_i = 1'b0; tick();
    endtask

    task automatic test_wait_and_midreset();
        apply_reset();
        for (int i = 0; i < 3; i++) pulse_enter();
        n_chk++; if (bus.count !== 3'd3 || bus.wait_est !== 16'(exp_wait(3)))
            $display("FAIL wait3: got cnt %0d wait %0d exp 3/%0d", bus.count, bus.wait_est, exp_wait(3)); else n_pass++;
        bus.leave_i = 1'b1; tick();
        n_chk++; if (bus.count !== 3'd2 || bus.wait_est !== 16'(exp_wait(2)))
            $display("FAIL wait2: got cnt %0d wait %0d exp 2/%0d", bus.count, bus.wait_est, exp_wait(2)); else n_pass++;
        bus.leave_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_chk++; if (bus.count !== 3'd0 || bus.wait_est !== 16'd0 || bus.empty !== 1'b1)
            $display("FAIL midrst: got cnt %0d wait %0d empty %b exp 0/0/1", bus.count, bus.wait_est, bus.empty); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        bus.enter_i = 1'b0;
        bus.leave_i = 1'b0;
        bus.err_clr = 1'b0;
        test_reset();
        test_fill_overflow();
        test_underflow_clear();
        test_simultaneous();
        test_clr_with_new_error();
        test_wait_and_midreset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/queue_occupancy_tracker.md
Name: queue_occupancy_tracker

Overview:
- Sequential successor to the combinational queue-manager flag logic.
- Counts people entering and leaving the waiting room from two gate sensors, using rising-edge detection on each.
- Produces registered occupancy plus full, empty and almost_full flags.
- Latches sticky overflow/underflow errors until software clears them.
- Generalised in counter width and almost-full threshold; optional wait-time estimate.

Parameters:
- CNT_W, 3: occupancy counter width; capacity MAX_CNT = 2**CNT_W - 1.
- AFULL_TH, 6: almost_full asserted when count >= AFULL_TH; legal range 1..MAX_CNT.
- SERVICE_CYC, 16: service time per person in clock cycles. Used only with WAIT_ESTIMATE_EN.
- WAIT_W, 16: width of wait_est.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enter_i  in  1  front-gate sensor level; a rising edge means one arrival.
- leave_i  in  1  service-desk sensor level; a rising edge means one departure.
- err_clr  in  1  single-cycle pulse that clears the sticky error.
- count  out  CNT_W  people currently waiting.
- full  out  1  count == MAX_CNT.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- error  out  1  sticky error present.
- err_code  out  2  00 none, 01 underflow (leave while empty), 10 overflow (enter while full).
- wait_est  out  WAIT_W  estimated wait in cycles (WAIT_ESTIMATE_EN only).

Behaviour:
- Reset (async, active-high):
  - count = 0, empty = 1, full = 0, almost_full = 0, error = 0, err_code = 00, wait_est = 0.
  - Sensor history registers reset to 1, so a sensor held high through reset is not counted.
- Edge detection: ent_ev = enter_i & ~enter_q and lv_ev = leave_i & ~leave_q. enter_q and leave_q are the values of enter_i and leave_i registered on the previous clock.
- Count update on the clock edge where an event is detected (new count visible one cycle after the sensor rises at the sampling edge):
  - ent_ev only, count < MAX_CNT: count + 1.
  - ent_ev only, count == MAX_CNT: count unchanged; overflow event.
  - lv_ev only, count > 0: count - 1.
  - lv_ev only, count == 0: count unchanged; underflow event.
  - ent_ev and lv_ev together: count unchanged; no error, even when full or empty (pass-through).
- Flags are decoded combinationally from the count register. They always agree with count, with no extra latency.
- Error FSM, two states, OK and ERR:
  - OK -> ERR on an overflow or underflow event; err_code latches that event's code.
  - ERR -> OK on err_clr, unless a new error event occurs in the same cycle. In that case the FSM stays in ERR and err_code takes the new code.
  - In ERR, further error events while err_clr = 0 do not change err_code; the first error is kept.
  - err_clr in OK has no effect.
  - error = (state == ERR).
- Counting continues normally while in ERR.
- Reset asserted mid-operation returns all state to reset values immediately.

Optional Feature:
- Macro WAIT_ESTIMATE_EN.
- Defined:
  - wait_est is registered and equals count * SERVICE_CYC, saturating at 2**WAIT_W - 1.
  - It is updated on the same edge as count, so it corresponds to the new count.
- Undefined: wait_est is tied to 0 and no multiplier logic is generated.

Decomposition:
- Package queue_pkg holds:
  - err_code localparams ERR_NONE = 2'b00, ERR_UNDER = 2'b01, ERR_OVER = 2'b10;
  - the FSM state typedef/encoding (ST_OK, ST_ERR).
- One sub-module: gate_edge_detect, a single-bit rising-edge detector with async reset-to-1. It is instantiated twice, for enter_i and leave_i.

Test Plan:
- Reset with enter_i held at 1, then release: count = 0, empty = 1, no event. Drop enter_i and raise it again: count = 1 on the next cycle, empty = 0.
- Seven enter edges from empty (CNT_W = 3): count = 7, full = 1, almost_full = 1 from count = 6. An eighth enter edge: count stays 7, error = 1, err_code = 10.
- From empty, one leave edge: count = 0, error = 1, err_code = 01. Then an overflow-free enter edge: count = 1, err_code stays 01. Pulse err_clr: error = 0, err_code = 00.
- At count = 7, enter and leave rise on the same cycle: count stays 7, error = 0. Repeat at count = 0: count stays 0, error = 0.
- In ERR (code 01), err_clr coincides with an overflow event at count = 7: error stays 1, err_code = 10.
- With WAIT_ESTIMATE_EN, SERVICE_CYC = 16, three enter edges: wait_est = 48 on the same cycle count becomes 3. Assert rst mid-sequence: wait_est = 0 and count = 0 immediately.
